// File: rtl/log_mul_pkg.sv
// Shared constants, types and the antilog helper for the Mitchell logarithmic multiplier.
package log_mul_pkg;

    localparam int WIDTH  = 16;
    localparam int FRAC_W = WIDTH - 1;
    localparam int K_W    = $clog2(WIDTH);
    localparam int PROD_W = 2 * WIDTH + 2;

    typedef logic [WIDTH-1:0]  operand_t;
    typedef logic [K_W-1:0]    char_t;
    typedef logic [FRAC_W-1:0] frac_t;
    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [K_W:0]      ksum_t;
    typedef logic [FRAC_W:0]   fsum_t;

    // The fraction carry bumps the exponent; the low FRAC_W bits of the shifted mantissa are dropped (floor).
    function automatic prod_t antilog(input ksum_t k, input fsum_t s);
        logic [FRAC_W:0]          m;
        logic [K_W+1:0]           e;
        logic [PROD_W+FRAC_W-1:0] wide;
        m    = {1'b1, s[FRAC_W-1:0]};
        e    = {1'b0, k} + {{(K_W+1){1'b0}}, s[FRAC_W]};
        wide = {{(PROD_W-1){1'b0}}, m} << e;
        return wide[PROD_W+FRAC_W-1:FRAC_W];
    endfunction

endpackage

// File: rtl/log_lod.sv
// Leading-one detector plus fraction normaliser: splits an operand into characteristic and left-aligned mantissa.
module log_lod
    import log_mul_pkg::*;
(
    input  logic [WIDTH-1:0]  n,
    output logic [K_W-1:0]    k,
    output logic [FRAC_W-1:0] f,
    output logic              zero
);

    operand_t norm;

    always_comb begin
        k = '0;
        // Ascending scan so the highest set bit wins.
        for (int i = 0; i < WIDTH; i++) begin
            if (n[i]) k = char_t'(i);
        end
        zero = (n == '0);
        norm = n << (char_t'(FRAC_W) - k);
        f    = norm[FRAC_W-1:0];
    end

endmodule

// File: rtl/log_multiplier1.sv
// Mitchell approximate unsigned multiplier, registered output.
// Define LOGMUL_PIPE_EN to register the characteristic/fraction sums (latency 2 instead of 1).
module log_multiplier1
    import log_mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  n1,
    input  logic [WIDTH-1:0]  n2,
    output logic [PROD_W-1:0] p0,
    output logic              zero_input_flag1,
    output logic              zero_input_flag2
);

    char_t k1, k2;
    frac_t f1, f2;
    logic  z1, z2;
    ksum_t k_sum;
    fsum_t f_sum;

    log_lod u_lod1 (.n(n1), .k(k1), .f(f1), .zero(z1));
    log_lod u_lod2 (.n(n2), .k(k2), .f(f2), .zero(z2));

    always_comb begin
        k_sum = {1'b0, k1} + {1'b0, k2};
        f_sum = {1'b0, f1} + {1'b0, f2};
    end

    // Antilog-stage operands; a_vld keeps a freshly reset pipeline from emitting antilog(0,0)=1.
    ksum_t a_k;
    fsum_t a_s;
    logic  a_z1, a_z2, a_vld;

`ifdef LOGMUL_PIPE_EN
    ksum_t ks_d, ks_q;
    fsum_t fs_d, fs_q;
    logic  z1_d, z1_q, z2_d, z2_q, vld_d, vld_q;

    always_comb begin
        ks_d  = k_sum;
        fs_d  = f_sum;
        z1_d  = z1;
        z2_d  = z2;
        vld_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ks_q  <= '0;
            fs_q  <= '0;
            z1_q  <= 1'b0;
            z2_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            ks_q  <= ks_d;
            fs_q  <= fs_d;
            z1_q  <= z1_d;
            z2_q  <= z2_d;
            vld_q <= vld_d;
        end
    end

    always_comb begin
        a_k   = ks_q;
        a_s   = fs_q;
        a_z1  = z1_q;
        a_z2  = z2_q;
        a_vld = vld_q;
    end
`else
    always_comb begin
        a_k   = k_sum;
        a_s   = f_sum;
        a_z1  = z1;
        a_z2  = z2;
        a_vld = 1'b1;
    end
`endif

    prod_t p0_d, p0_q;
    logic  flag1_d, flag1_q, flag2_d, flag2_q;

    always_comb begin
        p0_d    = '0;
        flag1_d = a_z1;
        flag2_d = a_z2;
        if (a_vld && !a_z1 && !a_z2) p0_d = antilog(a_k, a_s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p0_q    <= '0;
            flag1_q <= 1'b0;
            flag2_q <= 1'b0;
        end else begin
            p0_q    <= p0_d;
            flag1_q <= flag1_d;
            flag2_q <= flag2_d;
        end
    end

    assign p0               = p0_q;
    assign zero_input_flag1 = flag1_q;
    assign zero_input_flag2 = flag2_q;

endmodule

// File: tb/tb_log_multiplier1.sv
// Self-checking bench for log_multiplier1: directed table, reset sequences and randomized traffic vs. a formula model.
module tb_log_multiplier1;

`ifdef LOGMUL_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int W  = 16;
    localparam int PW = 2 * W + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  n1 = '0;
    logic [W-1:0]  n2 = '0;
    logic [PW-1:0] p0;
    logic          zero_input_flag1;
    logic          zero_input_flag2;

    int tests_run = 0;
    int tests_failed = 0;

    log_multiplier1 dut (
        .clk(clk), .rst(rst), .n1(n1), .n2(n2), .p0(p0),
        .zero_input_flag1(zero_input_flag1), .zero_input_flag2(zero_input_flag2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] p;
        logic          f1;
        logic          f2;
    } vec_t;

    typedef struct {
        logic [PW-1:0] p;
        logic          f1;
        logic          f2;
        longint unsigned prod;
    } exp_t;

    exp_t exp_q[$];

    // Mitchell's two cases with plain integer arithmetic; fractions scaled by 2^15.
    function automatic longint unsigned model_p(input logic [W-1:0] a, input logic [W-1:0] b);
        int ka, kb, k;
        longint unsigned fa, fb, s;
        if (a == 0 || b == 0) return 0;
        ka = 0;
        kb = 0;
        while ((64'd1 << (ka + 1)) <= a) ka++;
        while ((64'd1 << (kb + 1)) <= b) kb++;
        fa = (longint'(a) - (64'd1 << ka)) << (15 - ka);
        fb = (longint'(b) - (64'd1 << kb)) << (15 - kb);
        s  = fa + fb;
        k  = ka + kb;
        if (s < 64'd32768) return ((64'd32768 + s) << k) >> 15;
        else               return (s << (k + 1)) >> 15;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [PW-1:0] ep, input logic ef1, input logic ef2);
        tests_run++;
        if (p0 !== ep || zero_input_flag1 !== ef1 || zero_input_flag2 !== ef2) begin
            tests_failed++;
            $display("FAIL %s: got p0=%0d f1=%b f2=%b, expected p0=%0d f1=%b f2=%b",
                     name, p0, zero_input_flag1, zero_input_flag2, ep, ef1, ef2);
        end
    endtask

    task automatic check_bound(input string name, input longint unsigned prod);
        tests_run++;
        if (longint'(p0) > prod) begin
            tests_failed++;
            $display("FAIL %s: got p0=%0d, expected at most %0d", name, p0, prod);
        end
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{16'd2,     16'd3,     34'd6,          1'b0, 1'b0});
        vecs.push_back('{16'd256,   16'd1024,  34'd262144,     1'b0, 1'b0});
        vecs.push_back('{16'd1,     16'd65535, 34'd65535,      1'b0, 1'b0});
        vecs.push_back('{16'd3,     16'd3,     34'd8,          1'b0, 1'b0});
        vecs.push_back('{16'd5,     16'd7,     34'd32,         1'b0, 1'b0});
        vecs.push_back('{16'd65535, 16'd65535, 34'd4294836224, 1'b0, 1'b0});
        vecs.push_back('{16'd0,     16'd500,   34'd0,          1'b1, 1'b0});
        vecs.push_back('{16'd0,     16'd0,     34'd0,          1'b1, 1'b1});
        vecs.push_back('{16'd500,   16'd0,     34'd0,          1'b0, 1'b1});
        vecs.push_back('{16'd1,     16'd1,     34'd1,          1'b0, 1'b0});
        vecs.push_back('{16'd32768, 16'd32768, 34'd1073741824, 1'b0, 1'b0});

        // Reset held with live operands must keep outputs at zero.
        rst = 1'b1;
        n1  = 16'd100;
        n2  = 16'd200;
        step();
        step();
        check("reset_hold", '0, 1'b0, 1'b0);

        rst = 1'b0;
        repeat (LAT) step();
        check("after_reset_100x200", PW'(model_p(16'd100, 16'd200)), 1'b0, 1'b0);

        foreach (vecs[i]) begin
            n1 = vecs[i].a;
            n2 = vecs[i].b;
            repeat (LAT) step();
            check($sformatf("vec%0d_%0dx%0d", i, vecs[i].a, vecs[i].b), vecs[i].p, vecs[i].f1, vecs[i].f2);
            check("vec_model_agree", PW'(model_p(vecs[i].a, vecs[i].b)), vecs[i].f1, vecs[i].f2);
        end

        // Back-to-back random traffic with a one-cycle reset in the middle.
        exp_q.delete();
        for (int c = 0; c < 1000; c++) begin
            logic [W-1:0] a, b;
            exp_t e;
            a = W'($urandom_range(0, 65535));
            b = W'($urandom_range(0, 65535));
            if ($urandom_range(0, 15) == 0) a = '0;
            if ($urandom_range(0, 15) == 0) b = '0;
            if ($urandom_range(0, 7) == 0) a = W'(1) << $urandom_range(0, 15);
            n1 = a;
            n2 = b;
            if (c == 500) begin
                rst = 1'b1;
                step();
                check("midstream_reset", '0, 1'b0, 1'b0);
                rst = 1'b0;
                exp_q.delete();
                for (int j = 0; j < LAT - 1; j++) exp_q.push_back('{'0, 1'b0, 1'b0, 0});
                continue;
            end
            e.p    = PW'(model_p(a, b));
            e.f1   = (a == 0);
            e.f2   = (b == 0);
            e.prod = longint'(a) * longint'(b);
            exp_q.push_back(e);
            step();
            if (exp_q.size() >= LAT) begin
                exp_t x;
                x = exp_q.pop_front();
                check($sformatf("rand%0d", c), x.p, x.f1, x.f2);
                check_bound("rand_le_exact", x.prod);
            end
        end
        while (exp_q.size() > 0) begin
            exp_t x;
            step();
            x = exp_q.pop_front();
            check("rand_drain", x.p, x.f1, x.f2);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
